// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: sweep FSM states and
// default geometry.
package rf_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_DW  = 32;
    localparam int RF_AW  = 5;
    localparam int RF_NRD = 2;

endpackage

// File: rtl/rf_scoreboard_pend.sv
// Pending-write scoreboard: one bit per register, issue acceptance (WAW stall)
// and an incrementally maintained population count.
module rf_scoreboard_pend
    import rf_pkg::*;
#(
    parameter int AW      = RF_AW,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 clr_i,
    input  logic                 run_i,
    input  logic                 iss_i,
    input  logic [AW-1:0]        iss_wn_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        wn_i,
    input  logic                 flush_i,
    output logic                 iss_rdy_o,
    output logic [(1<<AW)-1:0]   pend_o,
    output logic [AW:0]          pend_cnt_o
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wb_hit, r0_iss, acc, set, inc, rel;

    always_comb begin
        wb_hit = we_i && (wn_i == iss_wn_i);
        r0_iss = ZERO_R0 && (iss_wn_i == '0);
        // A writeback to the same register this cycle retires the old producer,
        // so a new one may take its place.
        acc    = run_i && iss_i && !flush_i && !(pend_q[iss_wn_i] && !wb_hit);
        set    = acc && !r0_iss;
        inc    = set && !pend_q[iss_wn_i];
        rel    = run_i && we_i && pend_q[wn_i] && !(set && wb_hit);

        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (run_i && flush_i) begin
            pend_d = '0;
            cnt_d  = '0;
        end else begin
            if (rel) pend_d[wn_i]     = 1'b0;
            if (set) pend_d[iss_wn_i] = 1'b1;
            cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(rel);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign iss_rdy_o  = acc;
    assign pend_o     = pend_q;
    assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with N bypassed asynchronous read ports, one write port, a
// pending-write scoreboard and a post-reset clear sweep.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DW      = RF_DW,
    parameter int AW      = RF_AW,
    parameter int NRD     = RF_NRD,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*DW-1:0]   rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       wn,
    input  logic [DW-1:0]       wd,
    input  logic                iss,
    input  logic [AW-1:0]       iss_wn,
    output logic                iss_rdy,
    input  logic                flush,
    output logic                ready,
    output logic [AW:0]         pend_cnt
);

    localparam int DEPTH = 1 << AW;

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    ctr_q;
    logic             run;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] pend;
    logic             wr_ok;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_CLEAR;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) ctr_q <= ctr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && ctr_q == {AW{1'b1}}) state_d = ST_RUN;
    end

    always_comb begin
        run   = (state_q == ST_RUN);
        ready = run;
    end

    assign wr_ok = run && we && !(ZERO_R0 && wn == '0);

    // The sweep owns the write port until it finishes; writeback is dropped.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (!run)       mem_q[ctr_q] <= '0;
            else if (wr_ok) mem_q[wn]    <= wd;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic [DW-1:0] rdata;
        logic          hit;

        assign a   = ra[i*AW +: AW];
        assign hit = we && (wn == a);

        always_comb begin
            rdata = '0;
            if (run && !(ZERO_R0 && a == '0)) rdata = hit ? wd : mem_q[a];
        end

        assign rd[i*DW +: DW] = rdata;
        assign rbusy[i]       = run && pend[a] && !hit;
    end

    rf_scoreboard_pend #(
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_pend (
        .clk        (clk),
        .clr_i      (clr),
        .run_i      (run),
        .iss_i      (iss),
        .iss_wn_i   (iss_wn),
        .we_i       (we),
        .wn_i       (wn),
        .flush_i    (flush),
        .iss_rdy_o  (iss_rdy),
        .pend_o     (pend),
        .pend_cnt_o (pend_cnt)
    );

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: sweep, bypass, scoreboard, WAW, flush, clr.
module tb_rf_scoreboard;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    logic                clk = 1'b0;
    logic                clr;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*DW-1:0]   rd;
    logic [NRD-1:0]      rbusy;
    logic                we;
    logic [AW-1:0]       wn;
    logic [DW-1:0]       wd;
    logic                iss;
    logic [AW-1:0]       iss_wn;
    logic                iss_rdy;
    logic                flush;
    logic                ready;
    logic [AW:0]         pend_cnt;

    int checks = 0;
    int errors = 0;

    rf_scoreboard #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_R0(1'b1)) dut (
        .clk      (clk),
        .clr      (clr),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .we       (we),
        .wn       (wn),
        .wd       (wd),
        .iss      (iss),
        .iss_wn   (iss_wn),
        .iss_rdy  (iss_rdy),
        .flush    (flush),
        .ready    (ready),
        .pend_cnt (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
        #1;
    endtask

    // Counts cycles since the clr edge (current cycle = 1) until ready rises.
    task automatic wait_ready(output int n);
        n = 1;
        while (!ready && n < 100) begin
            tick;
            n++;
        end
    endtask

    int n;

    initial begin
        clr = 1'b1; ra = '0; we = 1'b0; wn = '0; wd = '0;
        iss = 1'b0; iss_wn = '0; flush = 1'b0;

        // Reset sweep with writeback/issue held active throughout (all ignored)
        tick;
        clr = 1'b0; we = 1'b1; wn = 5'd3; wd = 32'h55; iss = 1'b1; iss_wn = 5'd4;
        ra = {5'd4, 5'd3};
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_issrdy", iss_rdy, 0);
        chk("rst_rbusy", rbusy, 0);
        chk("rst_rd", rd, 0);
        chk("rst_pcnt", pend_cnt, 0);
        wait_ready(n);
        we = 1'b0; iss = 1'b0;
        chk("sweep_len", n, 33);
        chk("sweep_pcnt", pend_cnt, 0);
        for (int i = 0; i < 32; i++) begin
            set_ra(5'(i), 5'(31 - i));
            chk("sweep_rd0", rd[0 +: DW], 0);
            chk("sweep_rd1", rd[DW +: DW], 0);
        end
        tick;

        // Bypass write
        we = 1'b1; wn = 5'd7; wd = 32'hDEADBEEF; set_ra(5'd7, 5'd0);
        chk("byp_same", rd[0 +: DW], 32'hDEADBEEF);
        tick;
        we = 1'b0; #1;
        chk("byp_after", rd[0 +: DW], 32'hDEADBEEF);
        we = 1'b1; wn = 5'd0; wd = 32'h1234; set_ra(5'd7, 5'd0);
        chk("r0_same", rd[DW +: DW], 0);
        tick;
        we = 1'b0; #1;
        chk("r0_after", rd[DW +: DW], 0);

        // Scoreboard: issue r5, writeback four cycles later
        iss = 1'b1; iss_wn = 5'd5; set_ra(5'd0, 5'd5);
        chk("sb_issrdy", iss_rdy, 1);
        chk("sb_busy_t0", rbusy[1], 0);
        tick;
        iss = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("sb_busy", rbusy[1], 1);
            chk("sb_pcnt1", pend_cnt, 1);
            tick;
        end
        we = 1'b1; wn = 5'd5; wd = 32'hA5; #1;
        chk("sb_wb_busy", rbusy[1], 0);
        chk("sb_wb_rd", rd[DW +: DW], 32'hA5);
        chk("sb_wb_pcnt", pend_cnt, 1);
        tick;
        we = 1'b0; #1;
        chk("sb_rel_pcnt", pend_cnt, 0);
        chk("sb_rel_busy", rbusy[1], 0);
        chk("sb_rel_rd", rd[DW +: DW], 32'hA5);

        // WAW stall and same-cycle writeback+issue priority
        iss = 1'b1; iss_wn = 5'd9; #1;
        chk("waw_first", iss_rdy, 1);
        tick;
        #1;
        chk("waw_stall", iss_rdy, 0);
        tick;
        chk("waw_pcnt", pend_cnt, 1);
        we = 1'b1; wn = 5'd9; wd = 32'h99; #1;
        chk("waw_wb_acc", iss_rdy, 1);
        tick;
        we = 1'b0; iss = 1'b0; set_ra(5'd9, 5'd0);
        chk("waw_pend", rbusy[0], 1);
        chk("waw_pcnt2", pend_cnt, 1);
        chk("waw_rd", rd[0 +: DW], 32'h99);
        we = 1'b1; wn = 5'd9; tick;
        we = 1'b0; #1;
        chk("waw_clean", pend_cnt, 0);

        // Set one bit and release another on the same edge
        iss = 1'b1; iss_wn = 5'd10; tick;
        iss_wn = 5'd11; we = 1'b1; wn = 5'd10; wd = 32'h10; tick;
        iss = 1'b0; we = 1'b0; #1;
        chk("swap_pcnt", pend_cnt, 1);
        set_ra(5'd10, 5'd11);
        chk("swap_busy", rbusy, 2'b10);
        we = 1'b1; wn = 5'd11; tick;
        we = 1'b0; #1;
        chk("swap_clean", pend_cnt, 0);

        // Flush with r3, r4, r6 pending and a simultaneous write
        iss = 1'b1;
        iss_wn = 5'd3; #1; chk("fl_iss3", iss_rdy, 1); tick;
        iss_wn = 5'd4; #1; chk("fl_iss4", iss_rdy, 1); tick;
        iss_wn = 5'd6; #1; chk("fl_iss6", iss_rdy, 1); tick;
        #1;
        chk("fl_pcnt3", pend_cnt, 3);
        flush = 1'b1; iss_wn = 5'd13; we = 1'b1; wn = 5'd12; wd = 32'hF00D; #1;
        chk("fl_issrdy", iss_rdy, 0);
        tick;
        flush = 1'b0; iss = 1'b0; we = 1'b0; set_ra(5'd3, 5'd12);
        chk("fl_pcnt", pend_cnt, 0);
        chk("fl_busy3", rbusy[0], 0);
        chk("fl_wr", rd[DW +: DW], 32'hF00D);
        set_ra(5'd4, 5'd6);
        chk("fl_busy46", rbusy, 0);
        set_ra(5'd13, 5'd3);
        chk("fl_busy13", rbusy, 0);

        // clr during RUN, then clr again mid-sweep
        iss = 1'b1; iss_wn = 5'd20; tick;
        iss = 1'b0; clr = 1'b1; tick;
        clr = 1'b0; #1;
        chk("clr_ready", ready, 0);
        chk("clr_pcnt", pend_cnt, 0);
        for (int k = 0; k < 10; k++) tick;
        clr = 1'b1; tick;
        clr = 1'b0;
        wait_ready(n);
        chk("resweep_len", n, 33);
        for (int i = 0; i < 32; i++) begin
            set_ra(5'(i), 5'(31 - i));
            chk("resweep_rd0", rd[0 +: DW], 0);
        end
        chk("resweep_busy", rbusy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
